// File: rtl/anim_sequencer_if.sv
// Request/status bundle between a character controller (master) and anim_sequencer (slave).
interface anim_sequencer_if;
  logic       punch_req;
  logic       special_req;
  logic       hit;
  logic       move_fwd;
  logic       move_back;
  logic [2:0] character_state;
  logic [1:0] move_state;
  logic [1:0] frame;
  logic       busy;
  logic       anim_done;

  modport master (
    output punch_req, special_req, hit, move_fwd, move_back,
    input  character_state, move_state, frame, busy, anim_done
  );

  modport slave (
    input  punch_req, special_req, hit, move_fwd, move_back,
    output character_state, move_state, frame, busy, anim_done
  );
endinterface

// File: rtl/anim_sequencer.sv
// Character animation sequencer: punch/special/injured one-shots plus walk-cycle framing.
// Optional ANIM_INPUT_BUFFER_EN keeps a one-deep request buffer for requests made while busy.
module anim_sequencer #(
  parameter int unsigned TICK_DIV     = 12_500_000,
  parameter int unsigned PUNCH_FRAMES = 3,
  parameter int unsigned INJ_FRAMES   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  anim_sequencer_if.slave bus
);

  localparam int unsigned    CW           = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  TICK_LAST    = CW'(TICK_DIV - 1);
  localparam logic [1:0]     PUNCH_LAST   = 2'(PUNCH_FRAMES - 1);
  localparam logic [1:0]     INJ_LAST     = 2'(INJ_FRAMES - 1);
  localparam logic [1:0]     SPECIAL_LAST = 2'd3;

  typedef enum logic [2:0] {
    ST_NORMAL  = 3'b000,
    ST_PUNCH   = 3'b001,
    ST_SPECIAL = 3'b010,
    ST_INJURED = 3'b100
  } state_t;

  typedef enum logic [1:0] {
    MV_IDLE = 2'b00,
    MV_FWD  = 2'b01,
    MV_BACK = 2'b10
  } move_t;

  state_t        state_q, state_d;
  move_t         move_q, move_d, move_in;
  logic [1:0]    frame_q, frame_d;
  logic [1:0]    last_frame;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

`ifdef ANIM_INPUT_BUFFER_EN
  typedef enum logic [1:0] {
    PEND_NONE    = 2'b00,
    PEND_PUNCH   = 2'b01,
    PEND_SPECIAL = 2'b10
  } pend_t;

  pend_t pend_q, pend_d;
`endif

  assign tick = (cnt_q == TICK_LAST);

  always_comb begin
    move_in = MV_IDLE;
    case ({bus.move_back, bus.move_fwd})
      2'b01:   move_in = MV_FWD;
      2'b10:   move_in = MV_BACK;
      default: move_in = MV_IDLE;
    endcase
  end

  always_comb begin
    last_frame = SPECIAL_LAST;
    case (state_q)
      ST_PUNCH:   last_frame = PUNCH_LAST;
      ST_INJURED: last_frame = INJ_LAST;
      default:    last_frame = SPECIAL_LAST;
    endcase
  end

  always_comb begin
    state_d = state_q;
    move_d  = MV_IDLE;
    frame_d = frame_q;
    done_d  = 1'b0;
`ifdef ANIM_INPUT_BUFFER_EN
    pend_d  = pend_q;
`endif

    case (state_q)
      ST_NORMAL: begin
`ifdef ANIM_INPUT_BUFFER_EN
        // Any request taken in NORMAL supersedes whatever was buffered.
        pend_d = PEND_NONE;
`endif
        if (bus.hit) begin
          state_d = ST_INJURED;
          frame_d = 2'd0;
        end else if (bus.special_req) begin
          state_d = ST_SPECIAL;
          frame_d = 2'd0;
        end else if (bus.punch_req) begin
          state_d = ST_PUNCH;
          frame_d = 2'd0;
`ifdef ANIM_INPUT_BUFFER_EN
        end else if (pend_q == PEND_SPECIAL) begin
          state_d = ST_SPECIAL;
          frame_d = 2'd0;
        end else if (pend_q == PEND_PUNCH) begin
          state_d = ST_PUNCH;
          frame_d = 2'd0;
`endif
        end else begin
          move_d = move_in;
          if (move_in != move_q) begin
            frame_d = 2'd0;
          end else if (tick) begin
            case (move_in)
              MV_FWD:  frame_d = (frame_q == 2'd0) ? 2'd1 : 2'd0;
              MV_BACK: frame_d = (frame_q == 2'd0) ? 2'd2 : 2'd0;
              default: frame_d = 2'd0;
            endcase
          end
        end
      end

      ST_PUNCH, ST_SPECIAL, ST_INJURED: begin
        if (bus.hit && (state_q != ST_INJURED)) begin
          state_d = ST_INJURED;
          frame_d = 2'd0;
`ifdef ANIM_INPUT_BUFFER_EN
          pend_d  = PEND_NONE;
`endif
        end else begin
`ifdef ANIM_INPUT_BUFFER_EN
          // Special overwrites a buffered punch; a punch never displaces a buffered special.
          if (bus.special_req) begin
            pend_d = PEND_SPECIAL;
          end else if (bus.punch_req && (pend_q != PEND_SPECIAL)) begin
            pend_d = PEND_PUNCH;
          end
`endif
          if (tick) begin
            if (frame_q == last_frame) begin
              state_d = ST_NORMAL;
              frame_d = 2'd0;
              done_d  = 1'b1;
              move_d  = move_in;
            end else begin
              frame_d = frame_q + 2'd1;
            end
          end
        end
      end

      default: begin
        state_d = ST_NORMAL;
        frame_d = 2'd0;
      end
    endcase

    busy_d = (state_d != ST_NORMAL);
    // Reload on every state change so each state's first frame is a full tick period.
    cnt_d  = ((state_d != state_q) || tick) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_NORMAL;
      move_q  <= MV_IDLE;
      frame_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef ANIM_INPUT_BUFFER_EN
      pend_q  <= PEND_NONE;
`endif
    end else begin
      state_q <= state_d;
      move_q  <= move_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
`ifdef ANIM_INPUT_BUFFER_EN
      pend_q  <= pend_d;
`endif
    end
  end

  assign bus.character_state = state_q;
  assign bus.move_state      = move_q;
  assign bus.frame           = frame_q;
  assign bus.busy            = busy_q;
  assign bus.anim_done       = done_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// Directed self-checking bench for anim_sequencer (TICK_DIV=4, PUNCH_FRAMES=3, INJ_FRAMES=3).
module tb_anim_sequencer;

  localparam logic [2:0] S_NORM = 3'b000;
  localparam logic [2:0] S_PUN  = 3'b001;
  localparam logic [2:0] S_SPC  = 3'b010;
  localparam logic [2:0] S_INJ  = 3'b100;
  localparam logic [1:0] M_IDLE = 2'b00;
  localparam logic [1:0] M_FWD  = 2'b01;
  localparam logic [1:0] M_BACK = 2'b10;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic [8:0] obs;
  logic [8:0] want;

  anim_sequencer_if bus ();

  anim_sequencer #(
    .TICK_DIV    (4),
    .PUNCH_FRAMES(3),
    .INJ_FRAMES  (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // {character_state, move_state, frame, busy, anim_done}
  assign obs = {bus.character_state, bus.move_state, bus.frame, bus.busy, bus.anim_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.punch_req = 1'b0; bus.special_req = 1'b0; bus.hit = 1'b0;
    bus.move_fwd = 1'b0; bus.move_back = 1'b0;
    step(2);
    want = {S_NORM, M_IDLE, 2'd0, 1'b0, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL reset_state got=%b want=%b", obs, want); end
    rst_n = 1'b1;
    step(1);
    want = {S_NORM, M_IDLE, 2'd0, 1'b0, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL idle_after_reset got=%b want=%b", obs, want); end
  endtask

  task automatic test_punch();
    bus.punch_req = 1'b1; step(1); bus.punch_req = 1'b0;
    want = {S_PUN, M_IDLE, 2'd0, 1'b1, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL punch_entry got=%b want=%b", obs, want); end
    step(3);
    want = {S_PUN, M_IDLE, 2'd0, 1'b1, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL punch_f0_hold got=%b want=%b", obs, want); end
    step(1);
    want = {S_PUN, M_IDLE, 2'd1, 1'b1, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL punch_f1 got=%b want=%b", obs, want); end
    step(4);
    want = {S_PUN, M_IDLE, 2'd2, 1'b1, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL punch_f2 got=%b want=%b", obs, want); end
    step(3);
    want = {S_PUN, M_IDLE, 2'd2, 1'b1, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL punch_f2_hold got=%b want=%b", obs, want); end
    step(1);
    want = {S_NORM, M_IDLE, 2'd0, 1'b0, 1'b1}; tests++; if (obs !== want) begin fails++; $display("FAIL punch_done got=%b want=%b", obs, want); end
    step(1);
    want = {S_NORM, M_IDLE, 2'd0, 1'b0, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL punch_done_pulse got=%b want=%b", obs, want); end
  endtask

  task automatic test_special();
    bus.special_req = 1'b1; bus.punch_req = 1'b1; step(1);
    bus.special_req = 1'b0; bus.punch_req = 1'b0;
    for (int f = 0; f < 4; f++) begin
      want = {S_SPC, M_IDLE, 2'(f), 1'b1, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL special_f%0d_start got=%b want=%b", f, obs, want); end
      step(3);
      want = {S_SPC, M_IDLE, 2'(f), 1'b1, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL special_f%0d_end got=%b want=%b", f, obs, want); end
      step(1);
    end
    want = {S_NORM, M_IDLE, 2'd0, 1'b0, 1'b1}; tests++; if (obs !== want) begin fails++; $display("FAIL special_done got=%b want=%b", obs, want); end
  endtask

  task automatic test_hit();
    bus.punch_req = 1'b1; step(1); bus.punch_req = 1'b0;
    step(4);
    want = {S_PUN, M_IDLE, 2'd1, 1'b1, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL hit_pre_punch_f1 got=%b want=%b", obs, want); end
    bus.hit = 1'b1; step(1); bus.hit = 1'b0;
    want = {S_INJ, M_IDLE, 2'd0, 1'b1, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL hit_injured_entry got=%b want=%b", obs, want); end
    step(4);
    want = {S_INJ, M_IDLE, 2'd1, 1'b1, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL injured_f1 got=%b want=%b", obs, want); end
    bus.hit = 1'b1; step(1); bus.hit = 1'b0;
    want = {S_INJ, M_IDLE, 2'd1, 1'b1, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL injured_rehit_ignored got=%b want=%b", obs, want); end
    step(3);
    want = {S_INJ, M_IDLE, 2'd2, 1'b1, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL injured_f2 got=%b want=%b", obs, want); end
    step(3);
    want = {S_INJ, M_IDLE, 2'd2, 1'b1, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL injured_f2_hold got=%b want=%b", obs, want); end
    step(1);
    want = {S_NORM, M_IDLE, 2'd0, 1'b0, 1'b1}; tests++; if (obs !== want) begin fails++; $display("FAIL injured_done got=%b want=%b", obs, want); end
  endtask

  // Entered at the clk an animation returned to NORMAL (tick counter just reloaded).
  task automatic test_move();
    bus.move_fwd = 1'b1; step(1);
    want = {S_NORM, M_FWD, 2'd0, 1'b0, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL move_fwd_start got=%b want=%b", obs, want); end
    step(2);
    want = {S_NORM, M_FWD, 2'd0, 1'b0, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL move_fwd_f0_hold got=%b want=%b", obs, want); end
    step(1);
    want = {S_NORM, M_FWD, 2'd1, 1'b0, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL move_fwd_f1 got=%b want=%b", obs, want); end
    step(4);
    want = {S_NORM, M_FWD, 2'd0, 1'b0, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL move_fwd_f0 got=%b want=%b", obs, want); end
    step(4);
    want = {S_NORM, M_FWD, 2'd1, 1'b0, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL move_fwd_f1_again got=%b want=%b", obs, want); end
    bus.move_back = 1'b1; step(1);
    want = {S_NORM, M_IDLE, 2'd0, 1'b0, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL move_both_idle got=%b want=%b", obs, want); end
    bus.move_fwd = 1'b0; step(1);
    want = {S_NORM, M_BACK, 2'd0, 1'b0, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL move_back_start got=%b want=%b", obs, want); end
    step(2);
    want = {S_NORM, M_BACK, 2'd2, 1'b0, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL move_back_f2 got=%b want=%b", obs, want); end
    step(4);
    want = {S_NORM, M_BACK, 2'd0, 1'b0, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL move_back_f0 got=%b want=%b", obs, want); end
    bus.move_back = 1'b0; step(1);
    want = {S_NORM, M_IDLE, 2'd0, 1'b0, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL move_release got=%b want=%b", obs, want); end
  endtask

  // Punch request lands in the same clk as a walk-cycle tick.
  task automatic test_tick_entry();
    bus.move_fwd = 1'b1; step(1);
    want = {S_NORM, M_FWD, 2'd0, 1'b0, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL tick_entry_walk got=%b want=%b", obs, want); end
    step(1);
    bus.punch_req = 1'b1; step(1); bus.punch_req = 1'b0; bus.move_fwd = 1'b0;
    want = {S_PUN, M_IDLE, 2'd0, 1'b1, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL tick_entry_punch got=%b want=%b", obs, want); end
    step(12);
    want = {S_NORM, M_IDLE, 2'd0, 1'b0, 1'b1}; tests++; if (obs !== want) begin fails++; $display("FAIL tick_entry_done got=%b want=%b", obs, want); end
  endtask

  task automatic test_hit_priority();
    bus.hit = 1'b1; bus.special_req = 1'b1; bus.punch_req = 1'b1; step(1);
    bus.hit = 1'b0; bus.special_req = 1'b0; bus.punch_req = 1'b0;
    want = {S_INJ, M_IDLE, 2'd0, 1'b1, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL hit_priority got=%b want=%b", obs, want); end
    step(12);
    want = {S_NORM, M_IDLE, 2'd0, 1'b0, 1'b1}; tests++; if (obs !== want) begin fails++; $display("FAIL hit_priority_done got=%b want=%b", obs, want); end
    step(1);
    want = {S_NORM, M_IDLE, 2'd0, 1'b0, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL hit_priority_no_restart got=%b want=%b", obs, want); end
  endtask

  task automatic test_buffer();
    bus.punch_req = 1'b1; step(1); bus.punch_req = 1'b0;
    step(4);
    bus.punch_req = 1'b1; step(1); bus.punch_req = 1'b0;
    want = {S_PUN, M_IDLE, 2'd1, 1'b1, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL buf_punch_no_restart got=%b want=%b", obs, want); end
    step(7);
    want = {S_NORM, M_IDLE, 2'd0, 1'b0, 1'b1}; tests++; if (obs !== want) begin fails++; $display("FAIL buf_first_done got=%b want=%b", obs, want); end
    step(1);
`ifdef ANIM_INPUT_BUFFER_EN
    want = {S_PUN, M_IDLE, 2'd0, 1'b1, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL buf_replay_punch got=%b want=%b", obs, want); end
    bus.special_req = 1'b1; step(1); bus.special_req = 1'b0;
    bus.punch_req = 1'b1; step(1); bus.punch_req = 1'b0;
    step(10);
    want = {S_NORM, M_IDLE, 2'd0, 1'b0, 1'b1}; tests++; if (obs !== want) begin fails++; $display("FAIL buf_second_done got=%b want=%b", obs, want); end
    step(1);
    want = {S_SPC, M_IDLE, 2'd0, 1'b1, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL buf_special_kept got=%b want=%b", obs, want); end
    step(16);
    want = {S_NORM, M_IDLE, 2'd0, 1'b0, 1'b1}; tests++; if (obs !== want) begin fails++; $display("FAIL buf_special_done got=%b want=%b", obs, want); end
    step(1);
    want = {S_NORM, M_IDLE, 2'd0, 1'b0, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL buf_cleared got=%b want=%b", obs, want); end
`else
    want = {S_NORM, M_IDLE, 2'd0, 1'b0, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL nobuf_discarded got=%b want=%b", obs, want); end
    step(12);
    want = {S_NORM, M_IDLE, 2'd0, 1'b0, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL nobuf_still_idle got=%b want=%b", obs, want); end
`endif
  endtask

  task automatic test_reset_mid();
    int done_seen;
    bus.special_req = 1'b1; step(1); bus.special_req = 1'b0;
    step(8);
    want = {S_SPC, M_IDLE, 2'd2, 1'b1, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL reset_mid_pre got=%b want=%b", obs, want); end
    rst_n = 1'b0; step(1);
    want = {S_NORM, M_IDLE, 2'd0, 1'b0, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL reset_mid_abort got=%b want=%b", obs, want); end
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.anim_done === 1'b1) done_seen++;
    end
    tests++; if (done_seen !== 0) begin fails++; $display("FAIL reset_mid_no_done pulses=%0d want=0", done_seen); end
    want = {S_NORM, M_IDLE, 2'd0, 1'b0, 1'b0}; tests++; if (obs !== want) begin fails++; $display("FAIL reset_mid_idle got=%b want=%b", obs, want); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.punch_req = 1'b0; bus.special_req = 1'b0; bus.hit = 1'b0;
    bus.move_fwd = 1'b0; bus.move_back = 1'b0;
    test_reset();
    test_punch();
    test_special();
    test_hit();
    test_move();
    test_tick_entry();
    test_hit_priority();
    test_buffer();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/anim_sequencer.md
ANIM_SEQUENCER -- requirements
Module: anim_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 12_500_000, clk cycles per animation frame tick (8 Hz at 100 MHz); legal range >= 2.
REQ-002 Parameter PUNCH_FRAMES, default 3, frame count of punch animation (range 1-4).
REQ-003 Parameter INJ_FRAMES, default 3, frame count of injured animation (range 1-4).
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 punch_req  input  1  punch request, sampled every clk.
REQ-007 special_req  input  1  special-attack request, sampled every clk.
REQ-008 hit  input  1  character struck, sampled every clk.
REQ-009 move_fwd  input  1  forward movement held.
REQ-010 move_back  input  1  backward movement held.
REQ-011 character_state  output  3  000 normal, 001 punch, 010 special, 100 injured; registered.
REQ-012 move_state  output  2  00 idle, 01 forward, 10 backward; registered.
REQ-013 frame  output  2  current sprite frame index; registered.
REQ-014 busy  output  1  high while character_state != 000.
REQ-015 anim_done  output  1  one-clk pulse when a one-shot animation returns to normal.

Function
REQ-016 Free-running tick counter counts 0..TICK_DIV-1; tick asserted for the one clk where counter == TICK_DIV-1, then wraps to 0.
REQ-017 Counter SHALL reload to 0 on every character_state change, so each state's first frame lasts exactly TICK_DIV clks.
REQ-018 State machine: NORMAL, PUNCH, SPECIAL, INJURED, encoded on character_state per REQ-011.
REQ-019 Priority per clk: hit > special_req > punch_req > buffered request > tick advance.
REQ-020 hit in NORMAL, PUNCH or SPECIAL -> INJURED on next clk, frame=0; any buffered request cleared.
REQ-021 hit while INJURED ignored (no restart).
REQ-022 NORMAL + special_req -> SPECIAL, frame=0, next clk; NORMAL + punch_req alone -> PUNCH, frame=0.
REQ-023 PUNCH/INJURED: each tick frame+1; tick at frame == N-1 (N = PUNCH_FRAMES/INJ_FRAMES) -> NORMAL, frame=0, anim_done=1 for that clk.
REQ-024 SPECIAL: frames 0,1,2 one tick each, then frame 3 (recovery) one tick, then NORMAL with anim_done pulse; total 4*TICK_DIV clks.
REQ-025 In NORMAL, move_state: move_fwd only -> 01, move_back only -> 10, both or neither -> 00; updated every clk.
REQ-026 In NORMAL, frame on each tick: move_state 01 toggles 0/1, 10 toggles 0/2, 00 forces 0; move_state change forces frame 0 immediately.
REQ-027 Outside NORMAL, move_state held at 00.
REQ-028 punch_req/special_req in NORMAL during the same clk as a tick: state entry wins, frame=0.

Reset
REQ-029 rst_n low at a clk edge: character_state=000, move_state=00, frame=0, busy=0, anim_done=0, tick counter=0, request buffer empty.
REQ-030 Reset mid-animation SHALL abort it without an anim_done pulse.

Configuration
REQ-031 Macro ANIM_INPUT_BUFFER_EN defined: one-deep buffer latches the last punch_req/special_req arriving while busy (special overwrites punch, punch does not overwrite special); on return to NORMAL the buffered request starts on the next clk and the buffer clears.
REQ-032 ANIM_INPUT_BUFFER_EN undefined: requests while busy are discarded; no buffer storage synthesised.

Verification (TICK_DIV=4, PUNCH_FRAMES=3, INJ_FRAMES=3)
REQ-033 Reset release, punch_req 1 clk -> next clk character_state=001 frame=0; frames 1,2 at +4,+8 clks; at +12 state=000, anim_done pulse.
REQ-034 special_req and punch_req same clk in NORMAL -> state=010; frames 0,1,2,3 for 4 clks each; NORMAL at +16 with anim_done.
REQ-035 hit at punch frame 1 -> next clk state=100 frame=0; second hit at injured frame 1 ignored; NORMAL 12 clks after first hit.
REQ-036 move_fwd held in NORMAL -> move_state=01, frame 0,1,0,1 every 4 clks; add move_back -> move_state=00, frame=0 next clk.
REQ-037 With ANIM_INPUT_BUFFER_EN: punch_req during punch frame 1 -> second PUNCH starts clk after anim_done; without macro: stays NORMAL.
REQ-038 rst_n low at special frame 2 -> next clk all outputs at reset values, no anim_done.
